// File: rtl/mfshift_pkg.sv
// mfshift_pkg: shared direction constants, default width and amount-width helper for the rotator
package mfshift_pkg;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT = 1'b0;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int amt_width(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/multifunction_shifter_rev_bit_reverse.sv
// bit_reverse: combinational bit-order reversal, o_data[i] = i_data[WIDTH-1-i]
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign o_data[i] = i_data[WIDTH-1-i];
    end
endmodule

// File: rtl/multifunction_shifter_rev.sv
// multifunction_shifter_rev: registered left/right rotator sharing one right-rotate core.
// Optional registered zero flag when MFSHIFT_ZERO_FLAG_EN is defined.
module multifunction_shifter_rev
    import mfshift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             lr,
    output logic [WIDTH-1:0] y
`ifdef MFSHIFT_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    logic [WIDTH-1:0] w_rev_a;
    logic [WIDTH-1:0] w_rev_r;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_stage [AMT_W+1];

    bit_reverse #(.WIDTH(WIDTH)) u_rev_pre (.i_data(a), .o_data(w_rev_a));

    assign w_stage[0] = (lr == DIR_RIGHT) ? a : w_rev_a;

    // stage k rotates right by 2^k when amt[k] is set
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = amt[k] ? ((w_stage[k] >> SH) | (w_stage[k] << (WIDTH - SH)))
                                     : w_stage[k];
    end

    bit_reverse #(.WIDTH(WIDTH)) u_rev_post (.i_data(w_stage[AMT_W]), .o_data(w_rev_r));

    assign w_res = (lr == DIR_RIGHT) ? w_stage[AMT_W] : w_rev_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= w_res;
        end
    end

`ifdef MFSHIFT_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b1;
        end else begin
            zero <= (w_res == '0);
        end
    end
`endif
endmodule

// File: tb/tb_multifunction_shifter_rev.sv
// tb_multifunction_shifter_rev: table vectors, edge-timing sequences, exhaustive and random checks
module tb_multifunction_shifter_rev;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [2:0]   amt = '0;
    logic         lr = 1'b1;
    logic [W-1:0] y;
`ifdef MFSHIFT_ZERO_FLAG_EN
    logic         zero;
`endif

    int pass_cnt = 0;
    int total = 0;

    multifunction_shifter_rev #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .amt(amt),
        .lr(lr),
        .y(y)
`ifdef MFSHIFT_ZERO_FLAG_EN
        ,
        .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [2:0]   amt;
        logic         lr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [W-1:0] model(input logic [W-1:0] v, input int n, input logic right);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = right ? v[(i + n) % W] : v[(i - n + W) % W];
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step(input logic r, input logic [W-1:0] va, input logic [2:0] vamt, input logic vlr);
        rst = r;
        a = va;
        amt = vamt;
        lr = vlr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'hFF, 3'd0, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 8'hFF, 3'd5, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'hB3, 3'd1, 1'b1, 8'hD9};
        tbl[3]  = '{1'b0, 8'hCA, 3'd3, 1'b1, 8'h59};
        tbl[4]  = '{1'b0, 8'h6C, 3'd2, 1'b0, 8'hB1};
        tbl[5]  = '{1'b0, 8'h99, 3'd4, 1'b0, 8'h99};
        tbl[6]  = '{1'b0, 8'hF0, 3'd0, 1'b0, 8'hF0};
        tbl[7]  = '{1'b0, 8'hF0, 3'd0, 1'b1, 8'hF0};
        tbl[8]  = '{1'b0, 8'h81, 3'd7, 1'b1, 8'h03};
        tbl[9]  = '{1'b1, 8'h55, 3'd1, 1'b1, 8'h00};
        tbl[10] = '{1'b0, 8'h12, 3'd5, 1'b0, 8'h42};
        tbl[11] = '{1'b0, 8'h80, 3'd1, 1'b1, 8'h40};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].a, tbl[i].amt, tbl[i].lr);
            check($sformatf("tbl%0d", i), y, tbl[i].exp);
`ifdef MFSHIFT_ZERO_FLAG_EN
            check_bit($sformatf("tbl%0d_zero", i), zero, tbl[i].exp == '0);
`endif
        end

        // inputs changed mid-cycle must not reach y before the next edge
        step(1'b0, 8'h0F, 3'd2, 1'b0);
        check("hold_pre", y, 8'h3C);
        a = 8'hA5;
        amt = 3'd3;
        lr = 1'b1;
        #3;
        check("hold_mid", y, 8'h3C);
        @(posedge clk);
        #1;
        check("hold_post", y, 8'hB4);

`ifdef MFSHIFT_ZERO_FLAG_EN
        step(1'b0, 8'h00, 3'd3, 1'b0);
        check_bit("zero_on_00", zero, 1'b1);
        step(1'b0, 8'h01, 3'd6, 1'b1);
        check_bit("zero_on_01", zero, 1'b0);
`endif

        for (int v = 0; v < 256; v++)
            for (int n = 0; n < W; n++)
                for (int d = 0; d < 2; d++) begin
                    step(1'b0, v[W-1:0], n[2:0], d[0]);
                    check($sformatf("exh_a%02h_n%0d_lr%0d", v, n, d), y, model(v[W-1:0], n, d[0]));
`ifdef MFSHIFT_ZERO_FLAG_EN
                    check_bit("exh_zero", zero, v == 0);
`endif
                end

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [2:0]   rn;
            logic         rd;
            logic         rr;
            ra = W'($urandom);
            rn = 3'($urandom);
            rd = 1'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            step(rr, ra, rn, rd);
            check($sformatf("rnd%0d", i), y, rr ? '0 : model(ra, int'(rn), rd));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
